// File: rtl/npc_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : npc_predictor_if
// Description : Fetch / EX-resolution / trap bundle between the pipeline and
//               the next-PC predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface npc_predictor_if;
  logic [31:0] pc_cur;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic [31:0] ex_pred_target;
  logic        ex_pred_taken;

  logic        trap_req;
  logic [31:0] trap_vec;
  logic        mret;
  logic [31:0] mepc;

  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  // Predictor side
  modport slave (
    input  pc_cur, ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target,
           ex_pred_target, ex_pred_taken, trap_req, trap_vec, mret, mepc,
    output next_pc, pred_taken, pred_target, flush, br_cnt, mis_cnt
  );

  // Pipeline side
  modport master (
    output pc_cur, ex_valid, ex_is_branch, ex_taken, ex_pc, ex_target,
           ex_pred_target, ex_pred_taken, trap_req, trap_vec, mret, mepc,
    input  next_pc, pred_taken, pred_target, flush, br_cnt, mis_cnt
  );
endinterface
`default_nettype wire

// File: rtl/npc_predictor.sv
`default_nettype none
// ============================================================================
// Module      : npc_predictor
// Description : Direct-mapped BTB with 2-bit counters, next-PC selection with
//               trap/mret/mispredict redirect, and branch perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_predictor #(
  parameter int ENTRIES = 16
) (
  input  wire              clk,
  input  wire              rst,
  npc_predictor_if.slave   bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [1:0] c_ctr_init  = 2'b01;
  localparam logic [1:0] c_ctr_alloc = 2'b10;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_mis_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_pred_taken;
  logic [31:0]        w_pred_target;
  logic [31:0]        w_seq_pc;

  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd;
  logic               w_upd_hit;
  logic               w_mispredict;
  logic [31:0]        w_next_pc;

  // Fetch-side lookup reads the registered table, so a same-index update
  // only becomes visible on the following cycle.
  assign w_idx         = bus.pc_cur[IDX_W+1:2];
  assign w_tag         = bus.pc_cur[31:IDX_W+2];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_pred_taken  = w_hit && r_ctr[w_idx][1];
  assign w_seq_pc      = bus.pc_cur + 32'd4;
  assign w_pred_target = w_pred_taken ? r_target[w_idx] : w_seq_pc;

  assign w_upd_idx = bus.ex_pc[IDX_W+1:2];
  assign w_upd_tag = bus.ex_pc[31:IDX_W+2];
  assign w_upd     = bus.ex_valid && bus.ex_is_branch;
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  assign w_mispredict = w_upd &&
                        ((bus.ex_taken != bus.ex_pred_taken) ||
                         (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));

  always_comb begin
    w_next_pc = w_pred_target;
    if (bus.trap_req) begin
      w_next_pc = bus.trap_vec;
    end else if (bus.mret) begin
      w_next_pc = bus.mepc;
    end else if (w_mispredict) begin
      w_next_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);
    end
  end

  assign bus.next_pc     = w_next_pc;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;
  assign bus.flush       = bus.trap_req || bus.mret || w_mispredict;
  assign bus.br_cnt      = r_br_cnt;
  assign bus.mis_cnt     = r_mis_cnt;

  // Training proceeds even while a trap or mret redirects fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= c_ctr_init;
      end
    end else if (w_upd) begin
      if (w_upd_hit) begin
        if (bus.ex_taken) begin
          if (r_ctr[w_upd_idx] != 2'b11) begin
            r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
          end
          r_target[w_upd_idx] <= bus.ex_target;
        end else if (r_ctr[w_upd_idx] != 2'b00) begin
          r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
        end
      end else if (bus.ex_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bus.ex_target;
        r_ctr[w_upd_idx]    <= c_ctr_alloc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_upd) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_mispredict) begin
        r_mis_cnt <= r_mis_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire
